rk05_sector_index_gen: RTL and testbench

Sector/index pulse source for the RK05/2315 disk emulator, including its own 1 µs timebase.
- Relay mode (real_drive=1): relays the 2310's active-low sector and index pulses, with synchronisation and edge detection.
- Emulation mode (real_drive=0): synthesises 165 µs pulses with the real drive's timing.
- In both modes, maintains the 2-bit sector address consumed by the read/write and bus-interface logic.

---
 rtl/rk05_sector_index_gen.sv | 111 +++++++++++
 tb/tb_rk05_sector_index_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rk05_sector_index_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rk05_sector_index_gen                                                    |
// | Sector/index pulse source (2310 relay or timed emulation) + 1us timebase |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rk05_sector_index_gen #(
  parameter int CLK_PER_US      = 40,
  parameter int PULSE_US        = 165,
  parameter int SECTOR_US       = 5000,
  parameter int SECTORS_PER_REV = 8,
  parameter int INDEX_OFFSET_US = 600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       real_drive,
  input  logic       BUS_SECTOR_L,
  input  logic       BUS_INDEX_L,
  output logic       clkenbl_1usec,
  output logic       clkenbl_sector,
  output logic       clkenbl_index,
  output logic       BUS_SECTOR_EMUL_H,
  output logic       BUS_INDEX_EMUL_H,
  output logic [1:0] Sector_Address
);

  localparam int c_REV_US = SECTOR_US * SECTORS_PER_REV;
  localparam int c_PW     = $clog2(CLK_PER_US);
  localparam int c_UW     = $clog2(c_REV_US);
  localparam int c_SW     = $clog2(SECTOR_US);

  logic [c_PW-1:0] r_prescale;
  logic [c_UW-1:0] r_us_count, w_us_next;
  logic [c_SW-1:0] r_sec_phase, w_phase_next;
  logic            w_tick;
  logic            r_sec_s1, r_sec_s2, r_sec_hist;
  logic            r_idx_s1, r_idx_s2, r_idx_hist;
  logic            r_mode_s1, r_mode_s2;
  logic            w_emul_sector, w_emul_index, w_emul_sector_start, w_emul_index_start;
  logic            w_sel_sector, w_sel_index, w_sel_sector_edge, w_sel_index_edge;

  assign w_tick        = (r_prescale == c_PW'(CLK_PER_US - 1));
  assign clkenbl_1usec = w_tick;

  // Phase within the current sector slot runs alongside the revolution counter;
  // both start one step before zero so the first tick lands on sector 0.
  always_comb begin
    w_us_next    = r_us_count;
    w_phase_next = r_sec_phase;
    if (w_tick) begin
      w_us_next    = (r_us_count == c_UW'(c_REV_US - 1)) ? '0 : r_us_count + c_UW'(1);
      w_phase_next = (r_sec_phase == c_SW'(SECTOR_US - 1)) ? '0 : r_sec_phase + c_SW'(1);
    end
  end

  assign w_emul_sector       = (w_phase_next < c_SW'(PULSE_US));
  assign w_emul_sector_start = w_tick && (w_phase_next == '0);
  assign w_emul_index        = (w_us_next >= c_UW'(INDEX_OFFSET_US)) &&
                               (w_us_next <= c_UW'(INDEX_OFFSET_US + PULSE_US - 1));
  assign w_emul_index_start  = w_tick && (w_us_next == c_UW'(INDEX_OFFSET_US));

  assign w_sel_sector      = r_mode_s2 ? ~r_sec_s2 : w_emul_sector;
  assign w_sel_index       = r_mode_s2 ? ~r_idx_s2 : w_emul_index;
  assign w_sel_sector_edge = r_mode_s2 ? (r_sec_hist & ~r_sec_s2) : w_emul_sector_start;
  assign w_sel_index_edge  = r_mode_s2 ? (r_idx_hist & ~r_idx_s2) : w_emul_index_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prescale        <= '0;
      r_us_count        <= c_UW'(c_REV_US - 1);
      r_sec_phase       <= c_SW'(SECTOR_US - 1);
      r_sec_s1          <= 1'b1;
      r_sec_s2          <= 1'b1;
      r_sec_hist        <= 1'b1;
      r_idx_s1          <= 1'b1;
      r_idx_s2          <= 1'b1;
      r_idx_hist        <= 1'b1;
      r_mode_s1         <= 1'b0;
      r_mode_s2         <= 1'b0;
      clkenbl_sector    <= 1'b0;
      clkenbl_index     <= 1'b0;
      BUS_SECTOR_EMUL_H <= 1'b0;
      BUS_INDEX_EMUL_H  <= 1'b0;
      Sector_Address    <= 2'd0;
    end else begin
      r_prescale        <= w_tick ? '0 : r_prescale + c_PW'(1);
      r_us_count        <= w_us_next;
      r_sec_phase       <= w_phase_next;
      r_sec_s1          <= BUS_SECTOR_L;
      r_sec_s2          <= r_sec_s1;
      r_sec_hist        <= r_sec_s2;
      r_idx_s1          <= BUS_INDEX_L;
      r_idx_s2          <= r_idx_s1;
      r_idx_hist        <= r_idx_s2;
      r_mode_s1         <= real_drive;
      r_mode_s2         <= r_mode_s1;
      clkenbl_sector    <= w_sel_sector_edge;
      clkenbl_index     <= w_sel_index_edge;
      BUS_SECTOR_EMUL_H <= w_sel_sector;
      BUS_INDEX_EMUL_H  <= w_sel_index;
      // Index takes priority so a coincident sector edge still lands on sector 0.
      if (w_sel_index_edge)
        Sector_Address <= 2'd0;
      else if (w_sel_sector_edge)
        Sector_Address <= Sector_Address + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rk05_sector_index_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rk05_sector_index_gen                                                 |
// | Directed bench for the sector/index generator (shortened µs timings)     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rk05_sector_index_gen;

  localparam int c_CPU  = 40;
  localparam int c_PUS  = 10;
  localparam int c_SUS  = 50;
  localparam int c_SPR  = 8;
  localparam int c_IOFF = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       real_drive = 1'b0;
  logic       BUS_SECTOR_L = 1'b1;
  logic       BUS_INDEX_L = 1'b1;
  logic       clkenbl_1usec, clkenbl_sector, clkenbl_index;
  logic       BUS_SECTOR_EMUL_H, BUS_INDEX_EMUL_H;
  logic [1:0] Sector_Address;

  rk05_sector_index_gen #(
    .CLK_PER_US(c_CPU), .PULSE_US(c_PUS), .SECTOR_US(c_SUS),
    .SECTORS_PER_REV(c_SPR), .INDEX_OFFSET_US(c_IOFF)
  ) dut (
    .clock(clock), .reset(reset), .real_drive(real_drive),
    .BUS_SECTOR_L(BUS_SECTOR_L), .BUS_INDEX_L(BUS_INDEX_L),
    .clkenbl_1usec(clkenbl_1usec), .clkenbl_sector(clkenbl_sector),
    .clkenbl_index(clkenbl_index), .BUS_SECTOR_EMUL_H(BUS_SECTOR_EMUL_H),
    .BUS_INDEX_EMUL_H(BUS_INDEX_EMUL_H), .Sector_Address(Sector_Address)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         us;
    logic       sec;
    logic       idx;
    logic [1:0] addr;
  } emul_vec_t;

  emul_vec_t tbl[18];
  int        total = 0;
  int        bad = 0;
  int        cyc = 0;
  bit        mon_on = 1'b0;
  int        mon_last = 0;
  int        n_sec = 0;
  int        n_idx = 0;

  always @(negedge clock) begin
    if (mon_on && cyc <= mon_last) begin
      n_sec += int'(clkenbl_sector);
      n_idx += int'(clkenbl_index);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset(input logic mode);
    @(negedge clock);
    reset = 1'b0;
    real_drive = mode;
    BUS_SECTOR_L = 1'b1;
    BUS_INDEX_L = 1'b1;
    repeat (3) @(negedge clock);
    check("reset outputs", {clkenbl_1usec, clkenbl_sector, clkenbl_index,
          BUS_SECTOR_EMUL_H, BUS_INDEX_EMUL_H, Sector_Address}, 0);
    reset = 1'b1;
    cyc = 0;
  endtask

  // Low pulse on one relay input; the selected output must be its inverse
  // three clocks late, with one enable cycle and the other source silent.
  task automatic relay_pulse(input bit is_idx, input int low, input logic [1:0] exp_addr);
    logic [3:0] act;
    logic       exp_lvl, exp_en;
    @(negedge clock);
    if (is_idx) BUS_INDEX_L = 1'b0; else BUS_SECTOR_L = 1'b0;
    for (int k = 1; k <= low + 5; k++) begin
      step();
      exp_lvl = (k >= 3 && k <= low + 2);
      exp_en  = (k == 3);
      act = is_idx ? {BUS_INDEX_EMUL_H, clkenbl_index, BUS_SECTOR_EMUL_H, clkenbl_sector}
                   : {BUS_SECTOR_EMUL_H, clkenbl_sector, BUS_INDEX_EMUL_H, clkenbl_index};
      check($sformatf("relay %s k=%0d lvl/en", is_idx ? "index" : "sector", k),
            act, {exp_lvl, exp_en, 2'b00});
      if (k == low) begin
        @(negedge clock);
        if (is_idx) BUS_INDEX_L = 1'b1; else BUS_SECTOR_L = 1'b1;
      end
    end
    check("relay address", Sector_Address, exp_addr);
  endtask

  initial begin
    int gl_cnt;
    tbl[0]  = '{0,   1'b1, 1'b0, 2'd1};
    tbl[1]  = '{5,   1'b1, 1'b0, 2'd1};
    tbl[2]  = '{6,   1'b1, 1'b1, 2'd0};
    tbl[3]  = '{9,   1'b1, 1'b1, 2'd0};
    tbl[4]  = '{10,  1'b0, 1'b1, 2'd0};
    tbl[5]  = '{15,  1'b0, 1'b1, 2'd0};
    tbl[6]  = '{16,  1'b0, 1'b0, 2'd0};
    tbl[7]  = '{49,  1'b0, 1'b0, 2'd0};
    tbl[8]  = '{50,  1'b1, 1'b0, 2'd1};
    tbl[9]  = '{100, 1'b1, 1'b0, 2'd2};
    tbl[10] = '{150, 1'b1, 1'b0, 2'd3};
    tbl[11] = '{200, 1'b1, 1'b0, 2'd0};
    tbl[12] = '{250, 1'b1, 1'b0, 2'd1};
    tbl[13] = '{359, 1'b1, 1'b0, 2'd3};
    tbl[14] = '{360, 1'b0, 1'b0, 2'd3};
    tbl[15] = '{399, 1'b0, 1'b0, 2'd3};
    tbl[16] = '{400, 1'b1, 1'b0, 2'd0};
    tbl[17] = '{406, 1'b1, 1'b1, 2'd0};

    // Emulation: timebase, then one full revolution of checkpoints.
    do_reset(1'b0);
    mon_on = 1'b1;
    mon_last = c_CPU + c_CPU * c_SPR * c_SUS - 1;
    for (int c = 1; c <= 45; c++) begin
      step();
      check($sformatf("tick c=%0d", cyc), clkenbl_1usec, (cyc % c_CPU) == (c_CPU - 1));
      if (cyc == 39) check("emul sector before first tick", BUS_SECTOR_EMUL_H, 1'b0);
      if (cyc == 40) check("emul first sector lvl/en", {BUS_SECTOR_EMUL_H, clkenbl_sector}, 2'b11);
      if (cyc == 41) check("emul sector enable width", clkenbl_sector, 1'b0);
    end
    for (int i = 0; i < 18; i++) begin
      wait_to(c_CPU * tbl[i].us + 60);
      check($sformatf("emul u=%0d sector", tbl[i].us), BUS_SECTOR_EMUL_H, tbl[i].sec);
      check($sformatf("emul u=%0d index", tbl[i].us), BUS_INDEX_EMUL_H, tbl[i].idx);
      check($sformatf("emul u=%0d address", tbl[i].us), Sector_Address, tbl[i].addr);
    end
    check("emul sector enables per rev", n_sec, 8);
    check("emul index enables per rev", n_idx, 1);
    mon_on = 1'b0;

    // Reset asserted mid-pulse clears outputs without a clock edge.
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("async reset outputs", {clkenbl_sector, clkenbl_index, BUS_SECTOR_EMUL_H,
             BUS_INDEX_EMUL_H, Sector_Address}, 0);
    @(negedge clock);
    reset = 1'b1;
    cyc = 0;
    wait_to(39);
    check("post-reset tick/sector @39", {clkenbl_1usec, BUS_SECTOR_EMUL_H}, 2'b10);
    step();
    check("post-reset sector @40", {BUS_SECTOR_EMUL_H, clkenbl_sector, Sector_Address}, 4'b1101);

    // Relay mode.
    do_reset(1'b1);
    wait_to(10);
    relay_pulse(1'b0, 20, 2'd1);
    relay_pulse(1'b1, 20, 2'd0);
    relay_pulse(1'b0, 20, 2'd1);
    relay_pulse(1'b0, 20, 2'd2);
    relay_pulse(1'b0, 20, 2'd3);
    relay_pulse(1'b0, 20, 2'd0);
    relay_pulse(1'b0, 20, 2'd1);

    // Coincident index and sector edges.
    @(negedge clock);
    BUS_SECTOR_L = 1'b0;
    BUS_INDEX_L = 1'b0;
    step();
    step();
    check("coincident k=2 enables", {clkenbl_sector, clkenbl_index}, 2'b00);
    step();
    check("coincident k=3 enables", {clkenbl_sector, clkenbl_index}, 2'b11);
    check("coincident address", Sector_Address, 2'd0);
    @(negedge clock);
    BUS_SECTOR_L = 1'b1;
    BUS_INDEX_L = 1'b1;
    repeat (6) step();

    // Single-clock glitch on the sector line.
    @(negedge clock);
    BUS_SECTOR_L = 1'b0;
    @(negedge clock);
    BUS_SECTOR_L = 1'b1;
    gl_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      gl_cnt += int'(clkenbl_sector);
    end
    check("glitch enables at most one", gl_cnt <= 1, 1);
    check("glitch address", Sector_Address, 2'(gl_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
